// File: rtl/spi_slave_regfile.sv
// SPI slave with a 2^ADDR_W x DATA_W register file, selectable CPOL/CPHA,
// command/address phase, auto-incrementing bursts and a system-side read port.
module spi_slave_regfile #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter bit CPOL   = 1'b0,
   parameter bit CPHA   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              nCs,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   input  logic [ADDR_W-1:0] sys_addr,
   output logic [DATA_W-1:0] sys_rdata,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy
);

   localparam int unsigned NREG = 1 << ADDR_W;
   localparam int          CW   = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
   localparam logic [CW-1:0] CMD_LAST = CW'(7);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t            state;
   logic [1:0]        cs_q, sck_q, mosi_q;
   logic              sck_d;
   logic [1:0]        vld;
   logic              armed;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-2:0] rx;
   logic [DATA_W-1:0] tx;
   logic [ADDR_W-1:0] addr;
   logic [CW-1:0]     bitcnt;

   logic cs_s, sck_s, mosi_s;
   logic sck_rise, sck_fall, lead, trail, smp, sft;

   assign cs_s     = cs_q[1];
   assign sck_s    = sck_q[1];
   assign mosi_s   = mosi_q[1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign lead     = CPOL ? sck_fall : sck_rise;
   assign trail    = CPOL ? sck_rise : sck_fall;
   assign smp      = ~cs_s & (CPHA ? trail : lead);
   assign sft      = ~cs_s & (CPHA ? lead : trail);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q   <= '1;
         sck_q  <= {2{CPOL}};
         sck_d  <= CPOL;
         mosi_q <= '0;
      end else begin
         cs_q   <= {cs_q[0], nCs};
         sck_q  <= {sck_q[0], sclk};
         sck_d  <= sck_s;
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   // armed only after a genuine (post-flush) high on nCs, so a frame cut by
   // reset cannot resume and commit once reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         miso      <= 1'b0;
         sys_rdata <= '0;
         wr_stb    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
         vld       <= '0;
         armed     <= 1'b0;
         rx        <= '0;
         tx        <= '0;
         addr      <= '0;
         bitcnt    <= '0;
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         wr_stb    <= 1'b0;
         busy      <= ~cs_s;
         sys_rdata <= regs[sys_addr];
         vld       <= {vld[0], 1'b1};
         if (vld[1] && cs_s) armed <= 1'b1;

         if (cs_s) begin
            state  <= IDLE;
            bitcnt <= '0;
            miso   <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (armed) begin
                     state  <= CMD;
                     bitcnt <= '0;
                     miso   <= 1'b0;
                  end
               end
               CMD: begin
                  if (smp) begin
                     rx <= {rx[DATA_W-3:0], mosi_s};
                     if (bitcnt == CMD_LAST) begin
                        addr   <= ADDR_W'({rx[6:0], mosi_s});
                        state  <= rx[6] ? RDATA : WDATA;
                        bitcnt <= '0;
                     end else begin
                        bitcnt <= bitcnt + 1'b1;
                     end
                  end
               end
               WDATA: begin
                  if (smp) begin
                     rx <= {rx[DATA_W-3:0], mosi_s};
                     if (bitcnt == LAST_BIT) begin
                        regs[addr] <= {rx, mosi_s};
                        wr_stb     <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= {rx, mosi_s};
                        addr       <= addr + ADDR_W'(1);
                        bitcnt     <= '0;
                     end else begin
                        bitcnt <= bitcnt + 1'b1;
                     end
                  end
               end
               RDATA: begin
                  if (smp) begin
                     bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
                  end else if (sft) begin
                     // A shift edge at bit 0 is the word boundary for both CPHA
                     // settings: fetch the next word and present its MSB.
                     if (bitcnt == '0) begin
                        tx   <= regs[addr] << 1;
                        miso <= regs[addr][DATA_W-1];
                        addr <= addr + ADDR_W'(1);
                     end else begin
                        miso <= tx[DATA_W-1];
                        tx   <= tx << 1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
